// File: rtl/inv_sub_shift_seq.sv
// AES InvShiftRows + InvSubBytes front stage; four computed inverse S-boxes
// reused over four cycles. Define INV_SUB_SHIFT_PARALLEL_EN for a 16-S-box, single-cycle BUSY.
module inv_sub_shift_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_packet,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_packet
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic [127:0] src_r;
  logic [127:0] result_r;
  logic [127:0] result_nxt_s;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
  logic [1:0]   col_r;
`endif

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 by square-and-multiply; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int k);
    return v[127-8*k -: 8];
  endfunction

  // Source byte feeding output byte k after the inverse row rotation.
  function automatic int src_index(input int k);
    int c;
    int r;
    c = k / 4;
    r = k % 4;
    return 4 * ((c - r + 4) % 4) + r;
  endfunction

  assign in_ready   = (state_r == IDLE);
  assign out_valid  = (state_r == DONE);
  assign out_packet = result_r;

  // Next-state decode for the accept / compute / deliver sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
`ifdef INV_SUB_SHIFT_PARALLEL_EN
        state_nxt_s = DONE;
`else
        if (col_r == 2'd3) state_nxt_s = DONE;
        else               state_nxt_s = BUSY;
`endif
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result bytes produced by the shared S-boxes this cycle.
  always_comb begin
    result_nxt_s = result_r;
`ifdef INV_SUB_SHIFT_PARALLEL_EN
    for (int k = 0; k < 16; k++) begin
      result_nxt_s[127-8*k -: 8] = inv_sbox(get_byte(src_r, src_index(k)));
    end
`else
    for (int r = 0; r < 4; r++) begin
      result_nxt_s[127-8*(4*int'(col_r)+r) -: 8] =
        inv_sbox(get_byte(src_r, src_index(4*int'(col_r)+r)));
    end
`endif
  end

  // State, source capture, column counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      src_r    <= 128'h0;
      result_r <= 128'h0;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
      col_r    <= 2'd0;
`endif
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            src_r <= in_packet;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
            col_r <= 2'd0;
`endif
          end
        end
        BUSY: begin
          result_r <= result_nxt_s;
`ifndef INV_SUB_SHIFT_PARALLEL_EN
          col_r    <= col_r + 2'd1;
`endif
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule
